// File: rtl/hamming_pkg.sv
// hamming_pkg: shared definitions for the Hamming(12,8)+p0 SECDED datapath.
//   CW_W / DATA_W : codeword and data widths
//   DATA_POS      : codeword positions holding d0..d7
//   dec_res_t     : one decoded word (data, flags, syndrome, repaired codeword)
//   hamming_encode_8 : data byte -> 13-bit codeword (bit 0 = overall parity)
package hamming_pkg;

  localparam int CW_W   = 13;
  localparam int DATA_W = 8;
  localparam int SYN_W  = 4;

  localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sec;
    logic              ded;
    logic [SYN_W-1:0]  syndrome;
    logic [CW_W-1:0]   fixed_code;
  } dec_res_t;

  function automatic logic [CW_W-1:0] hamming_encode_8(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0]  c;
    logic [SYN_W-1:0] s;
    c = '0;
    s = '0;
    for (int i = 0; i < DATA_W; i++) c[DATA_POS[i]] = d[i];
    for (int p = 1; p < CW_W; p++) if (c[p]) s ^= SYN_W'(p);
    // Parity bit at position 2^k cancels syndrome bit k, leaving s = 0.
    c[1] = s[0];
    c[2] = s[1];
    c[4] = s[2];
    c[8] = s[3];
    c[0] = ^c[CW_W-1:1];
    return c;
  endfunction

endpackage

// File: rtl/hamming_secded_core.sv
// hamming_secded_core: combinational SECDED logic, split in two halves so the
// scrubber can register the syndrome between them.
//   code  -> syn, q          : syndrome and overall parity of a raw codeword
//   code_r, syn_r, q_r -> res : correction decision for a registered word
module hamming_secded_core
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0]  code,
  output logic [SYN_W-1:0] syn,
  output logic             q,
  input  logic [CW_W-1:0]  code_r,
  input  logic [SYN_W-1:0] syn_r,
  input  logic             q_r,
  output dec_res_t         res
);

  always_comb begin
    syn = '0;
    for (int p = 1; p < CW_W; p++) if (code[p]) syn ^= SYN_W'(p);
    q = ^code;
  end

  logic [CW_W-1:0] fixed;

  always_comb begin
    fixed        = code_r;
    res          = '0;
    res.syndrome = syn_r;
    if (q_r) begin
      // Odd overall parity: one flipped bit; syndrome 0 means it was p0 itself.
      if (syn_r == '0) begin
        fixed[0] = ~code_r[0];
        res.sec  = 1'b1;
      end else if (syn_r <= SYN_W'(CW_W - 1)) begin
        fixed[syn_r] = ~code_r[syn_r];
        res.sec      = 1'b1;
      end else begin
        // Syndrome points past the word: at least three bits flipped.
        res.ded = 1'b1;
      end
    end else if (syn_r != '0) begin
      res.ded = 1'b1;
    end
    res.fixed_code = fixed;
    for (int i = 0; i < DATA_W; i++) res.data[i] = fixed[DATA_POS[i]];
  end

endmodule

// File: rtl/hamming_scrubber_8.sv
// hamming_scrubber_8: two-stage SECDED decoder with scrub write-back and
// saturating error counters.
//   in_valid/in_ready/in_code        : codeword input handshake
//   out_valid/out_ready/out_*        : decoded result handshake
//   wb_valid/wb_ack/wb_code          : repaired-codeword write-back handshake
//   clear_cnt, cnt_sec, cnt_ded      : error statistics
// Stage 1 holds the codeword with its syndrome; stage 2 holds the decision.
// A stage-2 entry retires once both its result and any write-back have been
// accepted, in either order or in the same cycle.
module hamming_scrubber_8 #(
  parameter int CW_W   = 13,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sec,
  output logic              out_ded,
  output logic [3:0]        out_syndrome,
  output logic              wb_valid,
  output logic [CW_W-1:0]   wb_code,
  input  logic              wb_ack,
  input  logic              clear_cnt,
  output logic [CNT_W-1:0]  cnt_sec,
  output logic [CNT_W-1:0]  cnt_ded
);

  logic [2:1]          vld_pipe;
  logic                rdy_en;     // holds in_ready low until the first edge after reset
  logic [CW_W-1:0]     s1_code;
  logic [3:0]          s1_syn;
  logic                s1_q;
  logic [3:0]          syn_c;
  logic                q_c;
  hamming_pkg::dec_res_t res;
  logic                wb_pending;
  logic                out_done;   // result already taken, waiting on write-back
  logic                out_ok, wb_ok, retire, s1_adv, in_fire;

  hamming_secded_core u_core (
    .code   (in_code),
    .syn    (syn_c),
    .q      (q_c),
    .code_r (s1_code),
    .syn_r  (s1_syn),
    .q_r    (s1_q),
    .res    (res)
  );

  assign out_valid = vld_pipe[2] & ~out_done;
  assign wb_valid  = vld_pipe[2] & wb_pending;
  assign out_ok    = out_done | (out_valid & out_ready);
  assign wb_ok     = ~wb_pending | wb_ack;
  assign retire    = vld_pipe[2] & out_ok & wb_ok;
  assign s1_adv    = vld_pipe[1] & (~vld_pipe[2] | retire);
  assign in_ready  = rdy_en & (~vld_pipe[1] | s1_adv);
  assign in_fire   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en       <= 1'b0;
      vld_pipe     <= '0;
      s1_code      <= '0;
      s1_syn       <= '0;
      s1_q         <= 1'b0;
      out_data     <= '0;
      out_sec      <= 1'b0;
      out_ded      <= 1'b0;
      out_syndrome <= '0;
      wb_code      <= '0;
      wb_pending   <= 1'b0;
      out_done     <= 1'b0;
    end else begin
      rdy_en <= 1'b1;

      if (in_fire) begin
        s1_code     <= in_code;
        s1_syn      <= syn_c;
        s1_q        <= q_c;
        vld_pipe[1] <= 1'b1;
      end else if (s1_adv) begin
        vld_pipe[1] <= 1'b0;
      end

      if (s1_adv) begin
        vld_pipe[2]  <= 1'b1;
        out_data     <= res.data;
        out_sec      <= res.sec;
        out_ded      <= res.ded;
        out_syndrome <= res.syndrome;
        wb_code      <= res.fixed_code;
        wb_pending   <= res.sec;
        out_done     <= 1'b0;
      end else if (retire) begin
        vld_pipe[2] <= 1'b0;
        wb_pending  <= 1'b0;
        out_done    <= 1'b0;
      end else begin
        if (out_valid && out_ready) out_done   <= 1'b1;
        if (wb_valid && wb_ack)     wb_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_sec <= '0;
      cnt_ded <= '0;
    end else if (clear_cnt) begin
      cnt_sec <= '0;
      cnt_ded <= '0;
    end else if (retire) begin
      if (out_sec && cnt_sec != {CNT_W{1'b1}}) cnt_sec <= cnt_sec + 1'b1;
      if (out_ded && cnt_ded != {CNT_W{1'b1}}) cnt_ded <= cnt_ded + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_scrubber_8.sv
module tb_hamming_scrubber_8;
  import hamming_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [12:0] in_code;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        out_sec, out_ded;
  logic [3:0]  out_syndrome;
  logic        wb_valid, wb_ack;
  logic [12:0] wb_code;
  logic        clear_cnt;
  logic [7:0]  cnt_sec, cnt_ded;

  hamming_scrubber_8 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sec(out_sec), .out_ded(out_ded), .out_syndrome(out_syndrome),
    .wb_valid(wb_valid), .wb_code(wb_code), .wb_ack(wb_ack),
    .clear_cnt(clear_cnt), .cnt_sec(cnt_sec), .cnt_ded(cnt_ded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] code;
    logic [7:0]  data;
    logic        sec;
    logic        ded;
    logic [3:0]  syn;
    logic        wb;
    logic [12:0] wbc;
  } vec_t;

  vec_t vecs [6];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   exp_sec = 0;
  int   exp_ded = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; sends one word and follows it to retirement.
  task automatic run_vec(input vec_t v, input string nm);
    out_ready = 1'b1;
    wb_ack    = 1'b0;
    in_valid  = 1'b1;
    in_code   = v.code;
    #1 check({nm, ".in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check({nm, ".latency"}, out_valid, 0);
    @(negedge clk);
    check({nm, ".out_valid"}, out_valid, 1);
    check({nm, ".data"}, out_data, v.data);
    check({nm, ".sec"}, out_sec, v.sec);
    check({nm, ".ded"}, out_ded, v.ded);
    check({nm, ".syndrome"}, out_syndrome, v.syn);
    check({nm, ".wb_valid"}, wb_valid, v.wb);
    if (v.wb) begin
      check({nm, ".wb_code"}, wb_code, v.wbc);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check({nm, ".wb_hold"}, wb_valid, 1);
        check({nm, ".wb_code_hold"}, wb_code, v.wbc);
        check({nm, ".out_taken"}, out_valid, 0);
      end
      wb_ack = 1'b1;
      @(negedge clk);
      wb_ack = 1'b0;
      check({nm, ".wb_done"}, wb_valid, 0);
    end else begin
      @(negedge clk);
    end
    exp_sec += int'(v.sec);
    exp_ded += int'(v.ded);
    check({nm, ".idle"}, out_valid, 0);
    check({nm, ".cnt_sec"}, cnt_sec, exp_sec);
    check({nm, ".cnt_ded"}, cnt_ded, exp_ded);
  endtask

  initial begin
    logic [7:0]  bp_data [4];
    logic [12:0] bp_code [4];
    int sent, rcv, acc;
    logic hs, fire;

    vecs[0] = '{13'h144E, 8'hA5, 1'b0, 1'b0, 4'd0,  1'b0, 13'h0000};
    vecs[1] = '{13'h140E, 8'hA5, 1'b1, 1'b0, 4'd6,  1'b1, 13'h144E};
    vecs[2] = '{13'h144F, 8'hA5, 1'b1, 1'b0, 4'd0,  1'b1, 13'h144E};
    vecs[3] = '{13'h100E, 8'h81, 1'b0, 1'b1, 4'd12, 1'b0, 13'h0000};
    vecs[4] = '{13'h0448, 8'h25, 1'b0, 1'b1, 4'd15, 1'b0, 13'h0000};
    vecs[5] = '{13'h154E, 8'hA5, 1'b1, 1'b0, 4'd8,  1'b1, 13'h144E};

    rst = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b0;
    wb_ack = 1'b0; clear_cnt = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.in_ready", in_ready, 0);
    check("rst.out_valid", out_valid, 0);
    check("rst.wb_valid", wb_valid, 0);
    check("rst.out_data", out_data, 0);
    check("rst.wb_code", wb_code, 0);
    check("rst.cnt_sec", cnt_sec, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst.in_ready_after", in_ready, 1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure: 4 clean words, consumer stalled for the first 5 cycles.
    for (int i = 0; i < 4; i++) begin
      bp_data[i] = 8'((i + 1) * 17);
      bp_code[i] = hamming_encode_8(bp_data[i]);
    end
    sent = 0; rcv = 0;
    for (int c = 0; c < 20; c++) begin
      out_ready = (c >= 5);
      in_valid  = (sent < 4);
      in_code   = bp_code[sent < 4 ? sent : 3];
      #1;
      fire = in_valid & in_ready;
      hs   = out_valid & out_ready;
      if (c == 2) begin
        check("bp.in_ready_low", in_ready, 0);
        check("bp.accepted", sent, 2);
      end
      if (hs) begin
        if (rcv < 4) begin
          check("bp.order", out_data, bp_data[rcv]);
          check("bp.sec", out_sec, 0);
        end
        rcv++;
      end
      if (fire) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp.received", rcv, 4);
    check("bp.drained", out_valid, 0);

    // Saturation: stream single-error words, write-back acked immediately.
    out_ready = 1'b1; wb_ack = 1'b1; acc = 0;
    for (int c = 0; c < 400 && acc < 200; c++) begin
      in_valid = 1'b1; in_code = 13'h140E;
      #1 if (in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("sat.accepted", acc, 200);
    check("sat.cnt_sec_203", cnt_sec, exp_sec + 200);
    acc = 0;
    for (int c = 0; c < 200 && acc < 56; c++) begin
      in_valid = 1'b1; in_code = 13'h140E;
      #1 if (in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("sat.cnt_sec_255", cnt_sec, 255);
    check("sat.cnt_ded", cnt_ded, exp_ded);
    wb_ack = 1'b0;

    // clear_cnt on the same edge as a DED retire wins.
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 13'h100E;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("clr.out_valid", out_valid, 1);
    out_ready = 1'b1; clear_cnt = 1'b1;
    @(negedge clk);
    clear_cnt = 1'b0;
    check("clr.retired", out_valid, 0);
    check("clr.cnt_ded", cnt_ded, 0);
    check("clr.cnt_sec", cnt_sec, 0);
    exp_sec = 0; exp_ded = 0;
    run_vec(vecs[1], "post_clr");

    // Reset with a write-back pending.
    out_ready = 1'b0; wb_ack = 1'b0;
    in_valid = 1'b1; in_code = 13'h140E;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid.wb_valid", wb_valid, 1);
    rst = 1'b0;
    #1;
    check("mid.out_valid", out_valid, 0);
    check("mid.wb_valid_rst", wb_valid, 0);
    check("mid.wb_code", wb_code, 0);
    check("mid.out_sec", out_sec, 0);
    check("mid.syndrome", out_syndrome, 0);
    check("mid.cnt_sec", cnt_sec, 0);
    check("mid.in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("mid.no_wb_after", wb_valid, 0);
    check("mid.no_out_after", out_valid, 0);
    check("mid.in_ready_after", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_scrubber_8.md
# hamming_scrubber_8

SECDED decoder and scrubber for the Hamming-protected 8-bit register datapath. It accepts 13-bit codewords read back from the protected register, computes the syndrome and overall parity, and returns corrected data with single-error and double-error flags. On every corrected single error it issues a write-back request carrying the repaired codeword, so the register can be scrubbed. It is the decode end of the register's parity-encode path and keeps saturating error statistics.

## Interface
Parameters:
- CW_W, 13, codeword width (Hamming(12,8) plus overall parity)
- DATA_W, 8, data width
- CNT_W, 8, error counter width

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  codeword present
- in_ready  out  1  pipeline can accept
- in_code  in  13  codeword; bit i = Hamming position i (1..12), bit 0 = overall even parity p0
- out_valid  out  1  decoded result present
- out_ready  in  1  consumer accepts result
- out_data  out  8  corrected data (raw data when DED)
- out_sec  out  1  single error corrected
- out_ded  out  1  uncorrectable error detected
- out_syndrome  out  4  Hamming syndrome of the received word
- wb_valid  out  1  scrub write-back request
- wb_code  out  13  repaired codeword
- wb_ack  in  1  write-back accepted
- clear_cnt  in  1  synchronous counter clear
- cnt_sec  out  8  saturating count of corrected words
- cnt_ded  out  8  saturating count of uncorrectable words

## Operation
- Layout: p1=pos1, p2=pos2, p4=pos4, p8=pos8. d0..d7 map to pos 3,5,6,7,9,10,11,12. p0 gives even parity over all 13 bits.
- Syndrome s = XOR of the indices of all set positions 1..12. q = XOR of all 13 bits.
- The result depends on s and q:
  - s=0, q=0: clean. sec=0, ded=0.
  - q=1, s=0: p0 is in error. Set sec=1, data unchanged, wb_code = in_code with bit 0 flipped.
  - q=1, 1<=s<=12: flip position s. Set sec=1, wb_code = repaired word.
  - q=1, s>12: set ded=1, no correction.
  - q=0, s!=0: set ded=1, out_data is the raw data bits, no write-back.
- Stage 1 registers the codeword, s and q. Stage 2 registers the decision, out_data, the flags and wb_code.
- Stage 2 retires its entry only when both of these hold (current cycle or earlier):
  - the out handshake is done (out_valid & out_ready);
  - any write-back is done: wb_pending is cleared by wb_valid & wb_ack.
- wb_pending is set when an entry with sec=1 enters stage 2. wb_valid = stage-2 valid & wb_pending.
- While stage 2 holds its entry, stage 1 holds too. in_ready = !stage1_valid | stage1_advances.
- Counters: on retire, cnt_sec increments if sec and cnt_ded increments if ded. Both saturate at 255. clear_cnt forces both to 0 and takes priority over a same-cycle increment.

## Timing
- Reset values: out_valid=0, wb_valid=0, out_data=0, out_sec=0, out_ded=0, out_syndrome=0, wb_code=0, cnt_sec=0, cnt_ded=0. in_ready=0 while rst is low and 1 from the first cycle after release.
- Latency: a word accepted at edge N is on the outputs with out_valid=1 after edge N+2.
- Throughput: 1 word/cycle when out_ready=1 and no write-back is pending. A pending write-back stalls the pipeline until wb_ack.
- out_valid, out_data, out_sec, out_ded, out_syndrome, wb_valid and wb_code are stable until their handshake completes.
- Simultaneous out handshake and wb_ack in one cycle: the entry retires in that cycle, and a new entry may load stage 2 on the same edge.
- Reset mid-operation: all entries are discarded, no write-back is issued, and the counters clear.

## Structure
- Package hamming_pkg holds:
  - CW_W, DATA_W;
  - the data-position constant array {3,5,6,7,9,10,11,12};
  - the decode-result struct (data, sec, ded, syndrome, fixed_code);
  - the function hamming_encode_8, shared with the encoder side and the bench.
- Sub-module hamming_secded_core: purely combinational syndrome/q/correct logic. The scrubber wraps it with the pipeline, write-back handshake and counters.

## Test plan
- Clean word: in_code=0x144E (data 0xA5), out_ready=1 -> 2 cycles later out_data=0xA5, sec=0, ded=0, syndrome=0, no wb_valid.
- Single data error: 0x140E -> out_data=0xA5, sec=1, syndrome=6, wb_valid with wb_code=0x144E held until wb_ack (ack delayed 3 cycles), cnt_sec=1.
- p0 error: 0x144F -> out_data=0xA5, sec=1, syndrome=0, wb_code=0x144E.
- Double error: 0x100E -> ded=1, syndrome=12, out_data=0x81, no wb_valid, cnt_ded=1. Triple error 0x0448 (s=15, q=1) -> ded=1.
- Back-pressure: 4 clean words back-to-back with out_ready low for 5 cycles -> in_ready drops after 2 words, no loss or duplication, results returned in order.
- Counters: 256 single-error words -> cnt_sec saturates at 255. clear_cnt in the same cycle as a retire -> 0. rst low mid-stream -> outputs return to their reset values.
